logic_accum_unit: RTL and testbench

LOGIC_ACCUM_UNIT -- requirements
Module: logic_accum_unit

---
 rtl/logic_accum_pkg.sv | 15 +
 rtl/logicunit_core.sv | 24 ++
 rtl/logic_accum_unit.sv | 98 +++++++++
 tb/tb_logic_accum_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/logic_accum_pkg.sv
// Shared op-codes and FSM state encoding for the logic accumulate unit.
package logic_accum_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_NOR = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/logicunit_core.sv
// Purely combinational WIDTH-bit bitwise operator selected by a 2-bit op-code.
module logicunit_core
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_NOR:  res = ~(x | y);
            OP_XOR:  res = x ^ y;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/logic_accum_unit.sv
// Bitwise single-op / accumulate-burst unit with a held, handshaked result.
// Optional LOGIC_ACCUM_ZERO_FLAG_EN adds a 'zero' output equal to (acc == 0).
module logic_accum_unit
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       control,
    input  logic             acc_mode,
    input  logic [LEN_W-1:0] burst_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_res;
    logic             take;

    // Follow-on burst beats fold into acc; A only matters on the first beat.
    assign op_x = (state == ACCUM) ? acc : A;
    assign take = in_valid && in_ready;

    logicunit_core #(.WIDTH(WIDTH)) u_core (
        .x  (op_x),
        .y  (B),
        .op (control),
        .res(op_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    acc <= op_res;
                    // burst_len of 0 or 1 both collapse to a one-beat transaction
                    if (acc_mode && burst_len > ONE) begin
                        cnt   <= burst_len - ONE;
                        state <= ACCUM;
                    end else begin
                        cnt       <= '0;
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ACCUM: if (take) begin
                    acc <= op_res;
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out = acc;

`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
    assign zero = (acc == '0);
`endif

endmodule

// File: tb/tb_logic_accum_unit.sv
// Directed bench for logic_accum_unit (WIDTH=8, LEN_W=4) with hand-computed results.
module tb_logic_accum_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [1:0] control;
    logic       acc_mode;
    logic [3:0] burst_len;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
    logic       zero;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic_accum_unit #(.WIDTH(8), .LEN_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .control  (control),
        .acc_mode (acc_mode),
        .burst_len(burst_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; offers one beat across the next posedge, returns at the following negedge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ctl,
                        input logic mode, input logic [3:0] len);
        A = a; B = b; control = ctl; acc_mode = mode; burst_len = len;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; control = '0; acc_mode = 1'b0; burst_len = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, 8'h00);
        reset = 1'b0;
        idle_cycle();

        // Single XOR, result one cycle after acceptance
        chk("xor_ready_before", in_ready, 1'b1);
        beat(8'hF0, 8'h3C, 2'd3, 1'b0, 4'd0);
        chk("xor_valid", out_valid, 1'b1);
        chk("xor_out", out, 8'hCC);
        chk("xor_in_ready", in_ready, 1'b0);
        consume();
        chk("xor_consumed_valid", out_valid, 1'b0);
        chk("xor_consumed_ready", in_ready, 1'b1);

        // AND burst of 3 with a stall cycle mid-burst; A ignored after beat 1
        beat(8'hFF, 8'hF0, 2'd0, 1'b1, 4'd3);
        chk("and_b1_valid", out_valid, 1'b0);
        chk("and_b1_out", out, 8'hF0);
        chk("and_b1_ready", in_ready, 1'b1);
        idle_cycle();
        chk("and_stall_out", out, 8'hF0);
        chk("and_stall_valid", out_valid, 1'b0);
        beat(8'h11, 8'h3C, 2'd0, 1'b0, 4'd9);
        chk("and_b2_out", out, 8'h30);
        chk("and_b2_valid", out_valid, 1'b0);
        beat(8'h22, 8'h0F, 2'd0, 1'b0, 4'd0);
        chk("and_b3_valid", out_valid, 1'b1);
        chk("and_b3_out", out, 8'h00);
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
        chk("and_zero", zero, 1'b1);
`endif
        consume();

        // Mixed ops: OR then NOR
        beat(8'h01, 8'h02, 2'd1, 1'b1, 4'd2);
        chk("mix_b1_out", out, 8'h03);
        beat(8'hAA, 8'h04, 2'd2, 1'b0, 4'd0);
        chk("mix_valid", out_valid, 1'b1);
        chk("mix_out", out, 8'hF8);
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
        chk("mix_zero", zero, 1'b0);
`endif
        consume();

        // burst_len=0 behaves as one beat
        beat(8'hAA, 8'h55, 2'd1, 1'b1, 4'd0);
        chk("len0_valid", out_valid, 1'b1);
        chk("len0_out", out, 8'hFF);

        // Backpressure in HOLD; an offered beat must not be taken
        A = 8'h0F; B = 8'h0F; control = 2'd3; acc_mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            chk("bp_out", out, 8'hFF);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_ready", in_ready, 1'b0);
        end
        // Consume with in_valid still high: no same-cycle acceptance
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("nobypass_valid", out_valid, 1'b0);
        chk("nobypass_ready", in_ready, 1'b1);
        chk("nobypass_out", out, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("after_bypass_out", out, 8'h00);
        chk("after_bypass_valid", out_valid, 1'b1);
        consume();

        // Mid-burst reset, with a simultaneous beat offered
        beat(8'hFF, 8'h0F, 2'd0, 1'b1, 4'd3);
        chk("mr_b1_out", out, 8'h0F);
        reset = 1'b1; in_valid = 1'b1; A = 8'h00; B = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_out", out, 8'h00);
        chk("mr_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk("mr_no_stale", out_valid, 1'b0);
        end
        beat(8'h0F, 8'h01, 2'd1, 1'b0, 4'd0);
        chk("mr_fresh_valid", out_valid, 1'b1);
        chk("mr_fresh_out", out, 8'h0F);

        // Reset while in HOLD drops the result
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("hr_valid", out_valid, 1'b0);
        chk("hr_out", out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
